// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the memory write-port arbiter.
// Source indices double as bit positions in the request/grant vectors.
package mem_arb_pkg;

    typedef logic [1:0] src_idx_t;

    localparam src_idx_t SRC_CPU = 2'd0;
    localparam src_idx_t SRC_DHT = 2'd1;
    localparam src_idx_t SRC_LDR = 2'd2;

    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        W0   = 2'd1,
        W1   = 2'd2
    } dht_state_e;

    // Cyclic successor in the order CPU, DHT, LDR.
    function automatic src_idx_t next_src(input src_idx_t s);
        return (s == SRC_LDR) ? SRC_CPU : s + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way arbiter with a one-hot grant: round robin or fixed priority CPU > DHT > LDR.
// The pointer holds the highest-priority source and advances past each winner.
module rr_arbiter3
    import mem_arb_pkg::*;
#(
    parameter int unsigned ARB_MODE = ARB_RR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic [2:0] grant
);

    src_idx_t ptr_q, ptr_d;
    src_idx_t first, second, third;

    always_comb begin
        grant  = '0;
        first  = (ARB_MODE == ARB_FIXED) ? SRC_CPU : ptr_q;
        second = next_src(first);
        third  = next_src(second);
        if (req[first]) begin
            grant[first] = 1'b1;
        end else if (req[second]) begin
            grant[second] = 1'b1;
        end else if (req[third]) begin
            grant[third] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        unique case (grant)
            3'b001:  ptr_d = next_src(SRC_CPU);
            3'b010:  ptr_d = next_src(SRC_DHT);
            3'b100:  ptr_d = next_src(SRC_LDR);
            default: ptr_d = ptr_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= SRC_CPU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_write_arbiter.sv
// Shares the memory write port among CPU stores, the loader and the DHT capture engine.
// Optional MEM_ARB_PROT_EN drops CPU writes outside [CODE_TOP, MEM_DEPTH) and pulses prot_fault.
module mem_write_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DHT_ADDR  = 1001,
    parameter int unsigned ARB_MODE  = ARB_RR,
    parameter int unsigned CODE_TOP  = 16,
    parameter int unsigned MEM_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_wr_valid,
    output logic              cpu_wr_ready,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    input  logic              ldr_wr_valid,
    output logic              ldr_wr_ready,
    input  logic [ADDR_W-1:0] ldr_wr_addr,
    input  logic [DATA_W-1:0] ldr_wr_data,
    input  logic [39:0]       dht_data_in,
    input  logic              dht_data_valid,
    output logic              dht_busy,
    output logic              dht_overrun,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              prot_fault
);

    dht_state_e        state_q, state_d;
    logic [39:0]       sample_q, sample_d;
    logic              overrun_q, overrun_d;
    logic [2:0]        req, grant;
    logic              drop;
    logic [ADDR_W-1:0] sel_addr, addr_q;
    logic [DATA_W-1:0] sel_data, data_q;
    logic              we_q, fault_q;

    // Requests are masked during reset so no handshake completes while state is cleared.
    assign req[SRC_CPU] = cpu_wr_valid & ~rst;
    assign req[SRC_DHT] = (state_q != IDLE) & ~rst;
    assign req[SRC_LDR] = ldr_wr_valid & ~rst;

    rr_arbiter3 #(
        .ARB_MODE(ARB_MODE)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .grant (grant)
    );

    assign cpu_wr_ready = grant[SRC_CPU];
    assign ldr_wr_ready = grant[SRC_LDR];

    always_comb begin
        state_d   = state_q;
        sample_d  = sample_q;
        overrun_d = overrun_q;
        unique case (state_q)
            IDLE: begin
                if (dht_data_valid) begin
                    sample_d = dht_data_in;
                    state_d  = W0;
                end
            end
            W0:      if (grant[SRC_DHT]) state_d = W1;
            W1:      if (grant[SRC_DHT]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A new sample mid-transfer wins; any word granted this cycle is still written.
        if (dht_data_valid && (state_q != IDLE)) begin
            overrun_d = 1'b1;
            sample_d  = dht_data_in;
            state_d   = W0;
        end
    end

    always_comb begin
        sel_addr = cpu_wr_addr;
        sel_data = cpu_wr_data;
        if (grant[SRC_DHT]) begin
            if (state_q == W0) begin
                sel_addr = ADDR_W'(DHT_ADDR);
                sel_data = DATA_W'(sample_q[31:0]);
            end else begin
                sel_addr = ADDR_W'(DHT_ADDR + 1);
                sel_data = DATA_W'(sample_q[39:32]);
            end
        end else if (grant[SRC_LDR]) begin
            sel_addr = ldr_wr_addr;
            sel_data = ldr_wr_data;
        end
    end

`ifdef MEM_ARB_PROT_EN
    assign drop = grant[SRC_CPU] &&
                  ((cpu_wr_addr < ADDR_W'(CODE_TOP)) || (cpu_wr_addr >= ADDR_W'(MEM_DEPTH)));
`else
    logic unused_prot_params;
    assign unused_prot_params = ^{CODE_TOP, MEM_DEPTH};
    assign drop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sample_q  <= '0;
            overrun_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sample_q  <= sample_d;
            overrun_q <= overrun_d;
            we_q      <= (|grant) && !drop;
            fault_q   <= drop;
            if ((|grant) && !drop) begin
                addr_q <= sel_addr;
                data_q <= sel_data;
            end
        end
    end

    assign dht_busy         = (state_q != IDLE);
    assign dht_overrun      = overrun_q;
    assign mem_write_enable = we_q;
    assign write_addr       = addr_q;
    assign write_data       = data_q;
    assign prot_fault       = fault_q;

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Directed bench for mem_write_arbiter: a scoreboard of expected memory writes plus
// cycle-level checks of handshakes, DHT sequencing, overrun, reset and protection.
module tb_mem_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_wr_valid, ldr_wr_valid, dht_data_valid;
    logic [31:0] cpu_wr_addr, cpu_wr_data, ldr_wr_addr, ldr_wr_data;
    logic [39:0] dht_data_in;
    logic        cpu_wr_ready, ldr_wr_ready, dht_busy, dht_overrun;
    logic        mem_write_enable, prot_fault;
    logic [31:0] write_addr, write_data;

    logic        fx_cpu_ready, fx_ldr_ready;
    logic        unused_fx_busy, unused_fx_ovr, unused_fx_we, unused_fx_fault;
    logic [31:0] unused_fx_addr, unused_fx_data;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_popped = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    mem_write_arbiter #(.ARB_MODE(0)) dut (
        .clk(clk), .rst(rst),
        .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
        .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
        .ldr_wr_valid(ldr_wr_valid), .ldr_wr_ready(ldr_wr_ready),
        .ldr_wr_addr(ldr_wr_addr), .ldr_wr_data(ldr_wr_data),
        .dht_data_in(dht_data_in), .dht_data_valid(dht_data_valid),
        .dht_busy(dht_busy), .dht_overrun(dht_overrun),
        .mem_write_enable(mem_write_enable), .write_addr(write_addr),
        .write_data(write_data), .prot_fault(prot_fault)
    );

    mem_write_arbiter #(.ARB_MODE(1)) dut_fixed (
        .clk(clk), .rst(rst),
        .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(fx_cpu_ready),
        .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
        .ldr_wr_valid(ldr_wr_valid), .ldr_wr_ready(fx_ldr_ready),
        .ldr_wr_addr(ldr_wr_addr), .ldr_wr_data(ldr_wr_data),
        .dht_data_in(dht_data_in), .dht_data_valid(dht_data_valid),
        .dht_busy(unused_fx_busy), .dht_overrun(unused_fx_ovr),
        .mem_write_enable(unused_fx_we), .write_addr(unused_fx_addr),
        .write_data(unused_fx_data), .prot_fault(unused_fx_fault)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        sb_q.push_back({a, d});
    endtask

    // Every observed write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mem_write_enable === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write", {63'd0, mem_write_enable}, 64'd0);
            end else begin
                check("write_addr_data", {write_addr, write_data}, sb_q.pop_front());
                n_popped++;
            end
        end
    end

    initial begin
        rst = 1'b1;
        cpu_wr_valid = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0;
        ldr_wr_valid = 1'b0; ldr_wr_addr = '0; ldr_wr_data = '0;
        dht_data_valid = 1'b0; dht_data_in = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_we", {63'd0, mem_write_enable}, 64'd0);
        check("rst_addr_data", {write_addr, write_data}, 64'd0);
        check("rst_flags", {60'd0, dht_busy, dht_overrun, prot_fault, cpu_wr_ready}, 64'd0);

        // CPU alone: accepted same cycle, written next cycle, once
        tick();
        cpu_wr_valid = 1'b1; cpu_wr_addr = 32'd12; cpu_wr_data = 32'd30;
        @(negedge clk);
        check("cpu_ready", {63'd0, cpu_wr_ready}, 64'd1);
        check("cpu_ldr_ready_idle", {63'd0, ldr_wr_ready}, 64'd0);
        push(32'd12, 32'd30);
        tick();
        cpu_wr_valid = 1'b0;
        @(negedge clk);
        check("cpu_ready_drop", {63'd0, cpu_wr_ready}, 64'd0);
        tick();
        @(negedge clk);
        check("single_write_we", {63'd0, mem_write_enable}, 64'd0);
        check("addr_hold", {32'd0, write_addr}, 64'd12);

        // CPU and LDR both requesting: CPU was served last, so LDR leads
        tick();
        cpu_wr_valid = 1'b1; cpu_wr_addr = 32'd100; cpu_wr_data = 32'hC000;
        ldr_wr_valid = 1'b1; ldr_wr_addr = 32'd200; ldr_wr_data = 32'hD000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rr_cpu_ready", {63'd0, cpu_wr_ready}, {63'd0, (i % 2) == 1});
            check("rr_ldr_ready", {63'd0, ldr_wr_ready}, {63'd0, (i % 2) == 0});
            check("fixed_cpu_ready", {63'd0, fx_cpu_ready}, 64'd1);
            check("fixed_ldr_starved", {63'd0, fx_ldr_ready}, 64'd0);
            if ((i % 2) == 0) push(ldr_wr_addr, ldr_wr_data);
            else              push(cpu_wr_addr, cpu_wr_data);
            tick();
            if ((i % 2) == 0) begin
                ldr_wr_addr = ldr_wr_addr + 1; ldr_wr_data = ldr_wr_data + 1;
            end else begin
                cpu_wr_addr = cpu_wr_addr + 1; cpu_wr_data = cpu_wr_data + 1;
            end
        end
        cpu_wr_valid = 1'b0; ldr_wr_valid = 1'b0;
        tick();

        // DHT sample split into two words, busy for two cycles
        dht_data_valid = 1'b1; dht_data_in = 40'hAB_1234_5678;
        tick();
        dht_data_valid = 1'b0;
        @(negedge clk);
        check("dht_busy_w0", {63'd0, dht_busy}, 64'd1);
        push(32'd1001, 32'h1234_5678);
        tick();
        @(negedge clk);
        check("dht_busy_w1", {63'd0, dht_busy}, 64'd1);
        push(32'd1002, 32'h0000_00AB);
        tick();
        @(negedge clk);
        check("dht_busy_done", {63'd0, dht_busy}, 64'd0);
        check("dht_no_overrun", {63'd0, dht_overrun}, 64'd0);

        // Overrun: second sample lands during W1 while that word is granted
        tick();
        dht_data_valid = 1'b1; dht_data_in = 40'h11_AAAA_0001;
        tick();
        dht_data_valid = 1'b0;
        @(negedge clk);
        push(32'd1001, 32'hAAAA_0001);
        tick();
        dht_data_valid = 1'b1; dht_data_in = 40'h22_BBBB_0002;
        @(negedge clk);
        check("ovr_before", {63'd0, dht_overrun}, 64'd0);
        push(32'd1002, 32'h0000_0011);
        tick();
        dht_data_valid = 1'b0;
        @(negedge clk);
        check("ovr_set", {63'd0, dht_overrun}, 64'd1);
        check("ovr_busy", {63'd0, dht_busy}, 64'd1);
        push(32'd1001, 32'hBBBB_0002);
        tick();
        @(negedge clk);
        push(32'd1002, 32'h0000_0022);
        tick();
        @(negedge clk);
        check("ovr_idle", {63'd0, dht_busy}, 64'd0);
        check("ovr_sticky", {63'd0, dht_overrun}, 64'd1);

        // Reset while DHT is in W0 and the CPU is requesting
        tick();
        dht_data_valid = 1'b1; dht_data_in = 40'h33_CCCC_0003;
        tick();
        dht_data_valid = 1'b0;
        rst = 1'b1;
        cpu_wr_valid = 1'b1; cpu_wr_addr = 32'd40; cpu_wr_data = 32'd7;
        tick();
        rst = 1'b0;
        cpu_wr_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_we", {63'd0, mem_write_enable}, 64'd0);
        check("mid_rst_addr_data", {write_addr, write_data}, 64'd0);
        check("mid_rst_flags", {61'd0, dht_busy, dht_overrun, prot_fault}, 64'd0);
        repeat (4) tick();
        @(negedge clk);
        check("post_rst_busy", {63'd0, dht_busy}, 64'd0);

        // Low CPU address: dropped only when protection is built in
        tick();
        cpu_wr_valid = 1'b1; cpu_wr_addr = 32'd5; cpu_wr_data = 32'd99;
        @(negedge clk);
        check("prot_cpu_ready", {63'd0, cpu_wr_ready}, 64'd1);
`ifndef MEM_ARB_PROT_EN
        push(32'd5, 32'd99);
`endif
        tick();
        cpu_wr_valid = 1'b0;
        ldr_wr_valid = 1'b1; ldr_wr_addr = 32'd5; ldr_wr_data = 32'd77;
        @(negedge clk);
`ifdef MEM_ARB_PROT_EN
        check("prot_fault_pulse", {63'd0, prot_fault}, 64'd1);
        check("prot_we_blocked", {63'd0, mem_write_enable}, 64'd0);
`else
        check("prot_fault_tied", {63'd0, prot_fault}, 64'd0);
`endif
        check("prot_ldr_ready", {63'd0, ldr_wr_ready}, 64'd1);
        push(32'd5, 32'd77);
        tick();
        ldr_wr_valid = 1'b0;
        @(negedge clk);
        check("prot_ldr_no_fault", {63'd0, prot_fault}, 64'd0);

        repeat (3) tick();
        check("sb_drained", 64'(sb_q.size()), 64'd0);
`ifdef MEM_ARB_PROT_EN
        check("write_count", 64'(n_popped), 64'd14);
`else
        check("write_count", 64'(n_popped), 64'd15);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
